rv32i_idtop: RTL
================

# rv32i_idTop

Instruction-decode stage of the RV32I pipeline, directly upstream of the execute stage. It accepts a fetched `pc`/`iw` pair each cycle and reads both source operands from an internal 32×32 register file. The register file takes its write port from writeback. The block registers `pc`, `iw`, `rs1_data` and `rs2_data` into the exact bundle the execute stage consumes, and adds a destination-register tag for downstream hazard tracking.

## Interface
Parameters:
- `NOP_IW`, default `32'h00000013` (`addi x0,x0,0`): instruction word injected on flush and reset.

Ports (reset is synchronous and active-high, sampled on the rising edge of `clk`):
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc_in`  in  32  PC of the fetched instruction.
- `iw_in`  in  32  fetched instruction word.
- `stall_in`  in  1  hold the current output bundle.
- `flush_in`  in  1  replace the next output bundle with a NOP.
- `wb_en_in`  in  1  register-file write enable from writeback.
- `wb_reg_in`  in  5  writeback destination.
- `wb_data_in`  in  32  writeback data.
- `df_ex_wb_en`, `df_mem_wb_en`  in  1  forwarding-source valid flags (EX and MEM stages).
- `df_ex_reg`, `df_mem_reg`  in  5  forwarding-source destination registers.
- `df_ex_data`, `df_mem_data`  in  32  forwarding-source data.
- `pc_out`  out  32  registered PC to the execute stage.
- `iw_out`  out  32  registered instruction word to the execute stage.
- `rs1_data_out`  out  32  registered rs1 operand.
- `rs2_data_out`  out  32  registered rs2 operand.
- `wb_en_out`  out  1  registered: this instruction writes a register.
- `wb_reg_out`  out  5  registered destination (`iw[11:7]`).

## Operation
- Source fields come from `iw_in`: rs1 = `iw_in[19:15]`, rs2 = `iw_in[24:20]`, rd = `iw_in[11:7]`. Fields are extracted for every format; the execute stage ignores unused operands.
- `wb_en_out` = 1 when the opcode is one of `0110011`, `0010011`, `0000011`, `1100111`, `1101111`, `0110111`, `0010111`, **and** rd ≠ 0. It is 0 for stores, branches, unknown opcodes and NOP.
- Register file:
  - `x0` reads as 0 always; writes to `x0` are discarded.
  - A write occurs at the rising edge when `wb_en_in` = 1, `wb_reg_in` ≠ 0 and `reset` = 0.
  - Writes occur regardless of `stall_in` and `flush_in`.
- Operand source priority, per operand, for a nonzero source register:
  1. EX forward, if `df_ex_wb_en` and `df_ex_reg` matches (macro only).
  2. MEM forward, if `df_mem_wb_en` and `df_mem_reg` matches (macro only).
  3. WB bypass, if `wb_en_in` and `wb_reg_in` matches (same-cycle write is visible to the read).
  4. Register file contents.
  - A source register of 0 always yields 0.
- Update priority per edge: `reset` > `flush_in` > `stall_in` > normal.
  - **reset:**
    - Outputs take their reset values: `pc_out` = 0, `iw_out` = `NOP_IW`, `rs1_data_out` = 0, `rs2_data_out` = 0, `wb_en_out` = 0, `wb_reg_out` = 0.
    - All 31 registers clear to 0.
    - Reset asserted mid-stall or mid-flush wins.
  - **flush:** `iw_out` = `NOP_IW`, `pc_out` = `pc_in`, operands = 0, `wb_en_out` = 0, `wb_reg_out` = 0. A flush overrides a simultaneous stall.
  - **stall:**
    - `pc_out`, `iw_out`, `wb_en_out` and `wb_reg_out` hold.
    - `rs1_data_out` and `rs2_data_out` are re-read each cycle using the rs fields of the held `iw_out`, with full priority resolution. A writeback landing during a stall therefore updates the held operands.
  - **normal:** all outputs load from `pc_in`/`iw_in` and the resolved operands.

## Timing
- Latency is 1 cycle: `iw_in` presented before edge N appears on outputs after edge N.
- Register-file write at edge N is visible to the register-file read after N. The same-cycle WB bypass also covers the read before N.
- All outputs are registered. The only combinational path is operand selection feeding the output registers.
- There is no handshake beyond `stall_in`/`flush_in`. Upstream must hold `pc_in`/`iw_in` while `stall_in` = 1.

## Configuration
- Macro: `RV32I_ID_FWD_EN`.
- **Defined:** EX and MEM forwarding is active with the priority above.
- **Undefined:** the `df_*` ports remain in the port list but are ignored. Operand resolution is WB bypass, then register file.

## Structure
- `rv32i_pkg` holds:
  - opcode localparams (`OP_R`, `OP_IMM`, `OP_LOAD`, `OP_JALR`, `OP_JAL`, `OP_LUI`, `OP_AUIPC`, `OP_STORE`, `OP_BRANCH`);
  - the `NOP_IW` constant;
  - field-slice helper functions for rs1, rs2 and rd.
- Sub-module `rv32i_regs`:
  - 31×32 storage with synchronous write and two combinational read ports;
  - synchronous clear on reset;
  - `x0` hardwired to 0.
- Bypass and forwarding muxes and the output registers live in `rv32i_idTop`.

## Test plan
- **Reset:** assert reset for 2 cycles with `iw_in` = `0x00000033`. Expect `iw_out` = `0x00000013`, all other outputs 0. After release, reading x5 returns 0.
- **Write then read, with WB bypass:**
  - Write x3 = 3 via WB, then present ADD x1,x3,x2 (`0x002180B3`) with x2 previously written to 2. Next cycle: `rs1_data_out` = 3, `rs2_data_out` = 2, `wb_en_out` = 1, `wb_reg_out` = 1.
  - Repeat with the x3 write in the same cycle as the read. Expect `rs1_data_out` = 3.
- **x0 protection:** WB write of x0 = `0xDEADBEEF`, then ADD x1,x0,x0. Expect both operands 0. SW `0x0020A023` gives `wb_en_out` = 0.
- **Stall/flush:**
  - With ADD x1,x3,x2 held under `stall_in` = 1, WB writes x3 = `0x12345678`. Next cycle: `rs1_data_out` = `0x12345678`, `pc_out` unchanged.
  - `flush_in` and `stall_in` both asserted: expect `iw_out` = `0x00000013`, `wb_en_out` = 0.
- **Forward priority (`RV32I_ID_FWD_EN`):** read x3 with EX = `0xAAAA0000`, MEM = `0xBBBB0000`, WB = `0xCCCC0000`, all targeting x3. Expect `0xAAAA0000`. Drop EX: expect `0xBBBB0000`. Without the macro: expect `0xCCCC0000`.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I opcodes, NOP constant and instruction field helpers.
package rv32i_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_IW = 32'h00000013;

  function automatic logic [4:0] f_rs1(input logic [31:0] iw);
    return iw[19:15];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] iw);
    return iw[24:20];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] iw);
    return iw[11:7];
  endfunction

  function automatic logic f_writes_rd(input logic [31:0] iw);
    return f_rd(iw) != 5'd0 && iw[6:0] inside {OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC};
  endfunction
endpackage

// File: rtl/rv32i_regs.sv
// rv32i_regs: 31x32 register file, sync write/clear, two async read ports, x0 reads 0.
module rv32i_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] mem [31:1];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) mem[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end
  assign rd1 = ra1 == 5'd0 ? '0 : mem[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : mem[ra2];
endmodule

// File: rtl/rv32i_idtop.sv
// rv32i_idtop: RV32I decode stage with regfile, WB bypass and output bundle registers.
// Define RV32I_ID_FWD_EN to enable EX/MEM operand forwarding ahead of the WB bypass.
module rv32i_idtop #(
  parameter logic [31:0] NOP_IW = rv32i_pkg::NOP_IW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_reg_in,
  input  logic [31:0] wb_data_in,
  input  logic        df_ex_wb_en,
  input  logic        df_mem_wb_en,
  input  logic [4:0]  df_ex_reg,
  input  logic [4:0]  df_mem_reg,
  input  logic [31:0] df_ex_data,
  input  logic [31:0] df_mem_data,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] rs1_data_out,
  output logic [31:0] rs2_data_out,
  output logic        wb_en_out,
  output logic [4:0]  wb_reg_out
);
  logic [31:0] src_iw, rf1, rf2, op1, op2;
  logic [4:0]  ra1, ra2;

  // While stalled, operands are re-read from the held instruction so late writebacks land.
  assign src_iw = stall_in ? iw_out : iw_in;
  assign ra1 = rv32i_pkg::f_rs1(src_iw);
  assign ra2 = rv32i_pkg::f_rs2(src_iw);

  rv32i_regs u_regs (
    .clk(clk), .reset(reset),
    .we(wb_en_in), .wa(wb_reg_in), .wd(wb_data_in),
    .ra1(ra1), .ra2(ra2), .rd1(rf1), .rd2(rf2)
  );

`ifdef RV32I_ID_FWD_EN
  function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf);
    return r == 5'd0 ? '0 :
           df_ex_wb_en && df_ex_reg == r ? df_ex_data :
           df_mem_wb_en && df_mem_reg == r ? df_mem_data :
           wb_en_in && wb_reg_in == r ? wb_data_in : rf;
  endfunction
`else
  logic unused_df;
  assign unused_df = ^{df_ex_wb_en, df_mem_wb_en, df_ex_reg, df_mem_reg, df_ex_data, df_mem_data};
  function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf);
    return r == 5'd0 ? '0 : wb_en_in && wb_reg_in == r ? wb_data_in : rf;
  endfunction
`endif

  always_comb begin
    op1 = resolve(ra1, rf1);
    op2 = resolve(ra2, rf2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out       <= '0;
      iw_out       <= NOP_IW;
      rs1_data_out <= '0;
      rs2_data_out <= '0;
      wb_en_out    <= 1'b0;
      wb_reg_out   <= '0;
    end else if (flush_in) begin
      pc_out       <= pc_in;
      iw_out       <= NOP_IW;
      rs1_data_out <= '0;
      rs2_data_out <= '0;
      wb_en_out    <= 1'b0;
      wb_reg_out   <= '0;
    end else if (stall_in) begin
      rs1_data_out <= op1;
      rs2_data_out <= op2;
    end else begin
      pc_out       <= pc_in;
      iw_out       <= iw_in;
      rs1_data_out <= op1;
      rs2_data_out <= op2;
      wb_en_out    <= rv32i_pkg::f_writes_rd(iw_in);
      wb_reg_out   <= rv32i_pkg::f_rd(iw_in);
    end
  end
endmodule
